// File: rtl/alu_pkg.sv
// Shared ALU-path definitions: result width and destination select encodings.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage : alu_pkg

// File: rtl/fifo_sync_nw.sv
// Single-clock FIFO whose head is a registered output that holds its last value when empty.
module fifo_sync_nw
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_s, empty_s, push_s, pop_s;

  assign full_s  = (occ_q == OCC_FULL);
  assign empty_s = (occ_q == {OCC_W{1'b0}});
  assign push_s  = push_i && !full_s;
  assign pop_s   = pop_i && !empty_s;

  // Pointer, occupancy and next-head computation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    head_d   = head_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    // The slot being written becomes the head when it is the next read location.
    if (occ_d != {OCC_W{1'b0}}) begin
      head_d = (push_s && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // State registers and storage array.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      head_q   <= {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      head_q   <= head_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

  assign head_o  = head_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;

endmodule : fifo_sync_nw

// File: rtl/demux_1to2_16bit_buf.sv
// Buffered 1:2 demux steering ALU results to writeback (A) or output port (B),
// with a private FIFO and a wrapping delivered-word counter per destination.
module demux_1to2_16bit_buf
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  input  logic             B_ready,
  output logic [CNT_W-1:0] A_count,
  output logic [CNT_W-1:0] B_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             full_a_s, full_b_s, empty_a_s, empty_b_s;
  logic             push_s, push_a_s, push_b_s, pop_a_s, pop_b_s;
  logic [CNT_W-1:0] a_count_q, a_count_d, b_count_q, b_count_d;

  // Only the selected FIFO's fullness matters; no lookahead past a stalled word.
  assign in_ready = (sel == SEL_B) ? !full_b_s : !full_a_s;
  assign push_s   = in_valid && in_ready;
  assign push_a_s = push_s && (sel == SEL_A);
  assign push_b_s = push_s && (sel == SEL_B);
  assign pop_a_s  = A_ready && !empty_a_s;
  assign pop_b_s  = B_ready && !empty_b_s;

  fifo_sync_nw #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_a_s),
    .pop_i   (pop_a_s),
    .din_i   (In),
    .head_o  (A),
    .full_o  (full_a_s),
    .empty_o (empty_a_s)
  );

  fifo_sync_nw #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_b_s),
    .pop_i   (pop_b_s),
    .din_i   (In),
    .head_o  (B),
    .full_o  (full_b_s),
    .empty_o (empty_b_s)
  );

  // Delivered-word counters advance on each accepted pop and wrap.
  always_comb begin
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (pop_a_s) begin
      a_count_d = a_count_q + CNT_ONE;
    end else begin
      a_count_d = a_count_q;
    end
    if (pop_b_s) begin
      b_count_d = b_count_q + CNT_ONE;
    end else begin
      b_count_d = b_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_count_q <= {CNT_W{1'b0}};
      b_count_q <= {CNT_W{1'b0}};
    end else begin
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign A_valid = !empty_a_s;
  assign B_valid = !empty_b_s;
  assign A_count = a_count_q;
  assign B_count = b_count_q;

endmodule : demux_1to2_16bit_buf

// File: tb/tb_demux_1to2_16bit_buf.sv
// Directed self-checking bench for the buffered 1:2 demux.
module tb_demux_1to2_16bit_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] In;
  logic        sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic        A_valid;
  logic        A_ready;
  logic [15:0] B;
  logic        B_valid;
  logic        B_ready;
  logic [7:0]  A_count;
  logic [7:0]  B_count;

  int checks = 0;
  int errors = 0;

  demux_1to2_16bit_buf dut (
    .clk(clk), .rst(rst), .In(In), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .A_valid(A_valid), .A_ready(A_ready),
    .B(B), .B_valid(B_valid), .B_ready(B_ready),
    .A_count(A_count), .B_count(B_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; In = 16'h0000; sel = 1'b0; A_ready = 1'b0; B_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (A_valid !== 1'b0) begin errors++; $display("FAIL reset_A_valid got %b exp 0", A_valid); end
    checks++; if (B_valid !== 1'b0) begin errors++; $display("FAIL reset_B_valid got %b exp 0", B_valid); end
    checks++; if (A !== 16'h0000) begin errors++; $display("FAIL reset_A got %h exp 0000", A); end
    checks++; if (B !== 16'h0000) begin errors++; $display("FAIL reset_B got %h exp 0000", B); end
    checks++; if (A_count !== 8'h00) begin errors++; $display("FAIL reset_A_count got %h exp 00", A_count); end
    checks++; if (B_count !== 8'h00) begin errors++; $display("FAIL reset_B_count got %h exp 00", B_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel0 got %b exp 1", in_ready); end
    sel = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel1 got %b exp 1", in_ready); end
  endtask

  task automatic test_routing();
    A_ready = 1'b1; B_ready = 1'b1;
    In = 16'h1234; sel = 1'b0; in_valid = 1'b1;
    tick();
    checks++; if (A_valid !== 1'b1 || A !== 16'h1234) begin errors++; $display("FAIL route_A got v=%b %h exp v=1 1234", A_valid, A); end
    checks++; if (B_valid !== 1'b0) begin errors++; $display("FAIL route_B_idle got v=%b exp 0", B_valid); end
    In = 16'hBEEF; sel = 1'b1;
    tick();
    checks++; if (B_valid !== 1'b1 || B !== 16'hBEEF) begin errors++; $display("FAIL route_B got v=%b %h exp v=1 beef", B_valid, B); end
    checks++; if (A_valid !== 1'b0 || A !== 16'h1234) begin errors++; $display("FAIL route_A_hold got v=%b %h exp v=0 1234", A_valid, A); end
    checks++; if (A_count !== 8'h01) begin errors++; $display("FAIL route_A_count got %h exp 01", A_count); end
    in_valid = 1'b0;
    tick();
    checks++; if (B_count !== 8'h01 || B_valid !== 1'b0) begin errors++; $display("FAIL route_B_count got %h v=%b exp 01 v=0", B_count, B_valid); end
    tick();
    checks++; if (A_count !== 8'h01 || B_count !== 8'h01) begin errors++; $display("FAIL route_idle_counts got %h %h exp 01 01", A_count, B_count); end
  endtask

  task automatic test_backpressure();
    A_ready = 1'b0; B_ready = 1'b0;
    In = 16'h0001; sel = 1'b0; in_valid = 1'b1;
    tick();
    In = 16'h0002;
    tick();
    In = 16'h0003; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_sel0 got %b exp 0", in_ready); end
    sel = 1'b1; In = 16'h00B0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_sel1 got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (B_valid !== 1'b1 || B !== 16'h00B0) begin errors++; $display("FAIL bp_B got v=%b %h exp v=1 00b0", B_valid, B); end
    checks++; if (A_valid !== 1'b1 || A !== 16'h0001) begin errors++; $display("FAIL bp_A_head got v=%b %h exp v=1 0001", A_valid, A); end
    tick();
    checks++; if (A_count !== 8'h01 || A !== 16'h0001) begin errors++; $display("FAIL bp_A_stalled got cnt=%h %h exp 01 0001", A_count, A); end
    A_ready = 1'b1;
    tick();
    checks++; if (A_valid !== 1'b1 || A !== 16'h0002 || A_count !== 8'h02) begin errors++; $display("FAIL bp_A_second got v=%b %h cnt=%h exp v=1 0002 02", A_valid, A, A_count); end
    tick();
    checks++; if (A_valid !== 1'b0 || A !== 16'h0002 || A_count !== 8'h03) begin errors++; $display("FAIL bp_A_drained got v=%b %h cnt=%h exp v=0 0002 03", A_valid, A, A_count); end
    B_ready = 1'b1;
    tick();
    checks++; if (B_valid !== 1'b0 || B_count !== 8'h02) begin errors++; $display("FAIL bp_B_drained got v=%b cnt=%h exp v=0 02", B_valid, B_count); end
  endtask

  task automatic test_throughput();
    A_ready = 1'b1; sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      In = 16'h1000 + 16'(i); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tp_in_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      checks++; if (A_valid !== 1'b1 || A !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL tp_A[%0d] got v=%b %h exp v=1 %h", i, A_valid, A, 16'h1000 + 16'(i)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (A_valid !== 1'b0 || A_count !== 8'h0B) begin errors++; $display("FAIL tp_A_count got v=%b cnt=%h exp v=0 0b", A_valid, A_count); end
  endtask

  task automatic test_wrap();
    B_ready = 1'b1; sel = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      In = 16'h2000 + 16'(k);
      tick();
      if (k == 253) begin
        checks++; if (B_count !== 8'hFF) begin errors++; $display("FAIL wrap_B_count_ff got %h exp ff", B_count); end
      end
      if (k == 254) begin
        checks++; if (B_count !== 8'h00) begin errors++; $display("FAIL wrap_B_count_00 got %h exp 00", B_count); end
        checks++; if (B !== 16'h20FE) begin errors++; $display("FAIL wrap_B_data got %h exp 20fe", B); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (B_count !== 8'h02 || B_valid !== 1'b0) begin errors++; $display("FAIL wrap_B_final got %h v=%b exp 02 v=0", B_count, B_valid); end
    checks++; if (A_count !== 8'h0B) begin errors++; $display("FAIL wrap_A_unchanged got %h exp 0b", A_count); end
  endtask

  task automatic test_midop_reset();
    A_ready = 1'b0; B_ready = 1'b0; in_valid = 1'b1;
    sel = 1'b0; In = 16'hAAA1; tick();
    In = 16'hAAA2; tick();
    sel = 1'b1; In = 16'hBBB1; tick();
    In = 16'hBBB2; tick();
    in_valid = 1'b0; sel = 1'b0; #1;
    checks++; if (in_ready !== 1'b0 || A_valid !== 1'b1 || B_valid !== 1'b1) begin errors++; $display("FAIL mr_full got rdy=%b va=%b vb=%b exp 0 1 1", in_ready, A_valid, B_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (A_valid !== 1'b0 || B_valid !== 1'b0) begin errors++; $display("FAIL mr_valids got %b %b exp 0 0", A_valid, B_valid); end
    checks++; if (A_count !== 8'h00 || B_count !== 8'h00) begin errors++; $display("FAIL mr_counts got %h %h exp 00 00", A_count, B_count); end
    checks++; if (A !== 16'h0000 || B !== 16'h0000) begin errors++; $display("FAIL mr_data got %h %h exp 0000 0000", A, B); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready got %b exp 1", in_ready); end
    A_ready = 1'b1; B_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (A_valid !== 1'b0 || B_valid !== 1'b0 || A_count !== 8'h00 || B_count !== 8'h00) begin errors++; $display("FAIL mr_stale[%0d] got va=%b vb=%b %h %h exp 0 0 00 00", j, A_valid, B_valid, A_count, B_count); end
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_throughput();
    test_wrap();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demux_1to2_16bit_buf
